rollover_monitor: RTL and testbench
===================================

# rollover_monitor

Downstream consumer of the 4-bit JK-based `counter` stage's carry outputs. It samples `rcos` (count 7/15 boundary) and `rcol` (count 15 terminal, full wrap) every clock. It counts full 16-count wraps in an armed window and raises a registered interrupt when a programmable number of wraps is reached. The interrupt is held until acknowledged, with sticky overflow for wraps that arrive while it is pending.

## Interface
- `CNT_W`, default 8: width of the wrap-event counter and threshold.

- `clk`  in  1  sole clock; all state updates on rising edge; same clock as the upstream `counter`.
- `clr`  in  1  asynchronous, active-high reset; same net as the upstream `counter` clear.
- `rcos`  in  1  upstream ripple carry (enable & Q1&Q2&Q3); high for the cycle the count sits at 7 or 15 with enable.
- `rcol`  in  1  upstream terminal carry (rcos & Q4); high for the cycle the count sits at 15 with enable.
- `arm`  in  1  level; 1 = monitoring window open.
- `threshold`  in  CNT_W  number of wraps that fires `irq`; sampled every cycle; 0 = never fire.
- `ack`  in  1  level/pulse; clears a pending `irq`.
- `evt_count`  out  CNT_W  wraps counted in the current window.
- `half_seen`  out  1  count-7 boundary passed in the current 16-count wrap.
- `irq`  out  1  threshold reached, awaiting `ack`.
- `ovf`  out  1  sticky; a wrap arrived while `irq` was pending.
- `state`  out  2  00 IDLE, 01 RUN, 10 FLAG; 11 is unused and recovers to IDLE.

## Operation
- Reset (`clr`=1, asynchronous): state IDLE, `evt_count`=0, `half_seen`=0, `irq`=0, `ovf`=0.
- A wrap event is `rcol`=1 at a rising edge. `rcol` is authoritative. `rcol`=1 with `rcos`=0 is illegal upstream, but it is still counted as a wrap.
- A half event is `rcos`=1 and `rcol`=0.
- IDLE:
  - Outputs hold.
  - `arm`=1 goes to RUN and clears `evt_count`, `half_seen` and `ovf` on the same edge. A wrap on that same edge is not counted.
- RUN:
  - A wrap sets `evt_count` to `evt_count`+1, mod 2^CNT_W.
  - If that incremented value equals a nonzero `threshold`, go to FLAG and set `irq`=1 on the same edge.
  - A half event sets `half_seen`. A wrap clears it.
  - `arm`=0 goes to IDLE and takes priority over a wrap on the same edge.
- FLAG:
  - `irq`=1 and `evt_count` holds.
  - A wrap with `ack`=0 sets `ovf`. `half_seen` keeps updating as in RUN.
  - `ack`=1 clears `irq` and sets `evt_count` to 0, then goes to RUN if `arm`=1, else IDLE.
  - A wrap on the same edge as `ack` (with `arm`=1) counts into the new window: `evt_count`=1, `ovf` unchanged. If `threshold`=1, FLAG is re-entered immediately.
  - `arm`=0 without `ack` goes to IDLE, clears `irq` and keeps `ovf`.
- A `threshold` change takes effect on the next compare. Lowering it below `evt_count` does not fire until `evt_count` wraps around to match.
- `ack` in IDLE or RUN is ignored.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Latency from a `rcol` sample edge:
  - `evt_count` updates after that edge.
  - `irq` rises after the same edge when the threshold is hit.
- `irq` falls after the edge that samples `ack`=1.
- With a free-running upstream `counter`, `rcos` pulses at cycles 7 and 15 of every 16, and `rcol` at cycle 15. `half_seen` is 1 from just after cycle 7 until just after cycle 15.
- Reset mid-operation drops all outputs to reset values immediately, with no clock edge needed. Release of `clr` is synchronous to `clk` at the system level.

## Test plan
- Reset, then `arm`=1, `threshold`=3, upstream enabled for 48 cycles -> `evt_count` 1,2,3 after each `rcol` edge. `irq`=1 and `state`=10 after the 3rd `rcol`, `ovf`=0.
- Hold FLAG with no `ack` for 2 more wraps -> `evt_count` stays 3, `ovf`=1 after the first extra `rcol`. `ack`=1 -> `irq`=0, `evt_count`=0, `state`=01, `ovf` still 1.
- `threshold`=1, `ack`=1 on the same edge as `rcol` while in FLAG -> `evt_count`=1, `irq` stays 1, `state` stays 10.
- `threshold`=0, 20 wraps -> `evt_count`=20, `irq` never asserts. `arm`=0 with a coincident `rcol` -> IDLE, `evt_count` stays 20.
- `half_seen`: free-running upstream -> rises after the count-7 edge, falls after the count-15 edge, every wrap.
- `clr` pulse asserted mid-FLAG, between clock edges -> `irq`, `ovf`, `evt_count`, `half_seen` = 0 and `state`=00 before the next edge. `arm` held at 1 -> RUN on the first edge after `clr` release.

Source files
------------

// File: rtl/rollover_monitor.sv
// rollover_monitor: counts full 16-count wraps of an upstream counter and raises a held interrupt at a threshold.
// Ports:
//   clk        sole clock, rising edge
//   clr        asynchronous active-high reset (shared with upstream counter clear)
//   rcos       upstream carry at count 7/15
//   rcol       upstream terminal carry at count 15 (a wrap)
//   arm        monitoring window open
//   threshold  wraps that fire irq; 0 never fires
//   ack        clears a pending irq
//   evt_count  wraps counted in the current window
//   half_seen  count-7 boundary passed in the current wrap
//   irq        threshold reached, awaiting ack
//   ovf        sticky, a wrap arrived while irq was pending
//   state      00 IDLE, 01 RUN, 10 FLAG
module rollover_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             rcos,
    input  logic             rcol,
    input  logic             arm,
    input  logic [CNT_W-1:0] threshold,
    input  logic             ack,
    output logic [CNT_W-1:0] evt_count,
    output logic             half_seen,
    output logic             irq,
    output logic             ovf,
    output logic [1:0]       state
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] FLAG = 2'b10;
    logic [CNT_W-1:0] inc, cnt_n;
    logic [1:0]       state_n;
    logic             half_n, irq_n, ovf_n, hit, half_upd, refire;
    assign inc      = evt_count + CNT_W'(1);
    assign hit      = (threshold != '0) && (inc == threshold);
    // rcol wins over rcos, so a terminal carry always closes the half window
    assign half_upd = rcol ? 1'b0 : (rcos ? 1'b1 : half_seen);
    // a wrap coincident with ack opens the new window at count 1
    assign refire   = rcol && (threshold == CNT_W'(1));
    always_comb begin
        state_n = state;
        cnt_n   = evt_count;
        half_n  = half_seen;
        irq_n   = irq;
        ovf_n   = ovf;
        case (state)
            IDLE: if (arm) begin
                state_n = RUN;
                cnt_n   = '0;
                half_n  = 1'b0;
                ovf_n   = 1'b0;
            end
            RUN: if (!arm) state_n = IDLE;
            else begin
                half_n = half_upd;
                if (rcol) begin
                    cnt_n = inc;
                    if (hit) begin
                        state_n = FLAG;
                        irq_n   = 1'b1;
                    end
                end
            end
            FLAG: begin
                half_n = half_upd;
                if (ack && arm) begin
                    cnt_n   = rcol ? CNT_W'(1) : '0;
                    irq_n   = refire;
                    state_n = refire ? FLAG : RUN;
                end else if (ack || !arm) begin
                    cnt_n   = ack ? '0 : evt_count;
                    irq_n   = 1'b0;
                    state_n = IDLE;
                end else ovf_n = ovf | rcol;
            end
            default: begin
                state_n = IDLE;
                irq_n   = 1'b0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            evt_count <= '0;
            half_seen <= 1'b0;
            irq       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_n;
            evt_count <= cnt_n;
            half_seen <= half_n;
            irq       <= irq_n;
            ovf       <= ovf_n;
        end
    end
endmodule

// File: tb/tb_rollover_monitor.sv
// tb_rollover_monitor: vector table plus free-running upstream sequences, scoreboarded.
module tb_rollover_monitor;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       rcos = 1'b0;
    logic       rcol = 1'b0;
    logic       arm = 1'b0;
    logic       ack = 1'b0;
    logic [7:0] threshold = 8'd0;
    logic [7:0] evt_count;
    logic       half_seen, irq, ovf;
    logic [1:0] state;
    logic [3:0] q = 4'd0;
    logic [12:0] sb[$];
    int n_vec = 0;
    int n_miss = 0;

    rollover_monitor #(.CNT_W(8)) dut (
        .clk(clk), .clr(clr), .rcos(rcos), .rcol(rcol), .arm(arm),
        .threshold(threshold), .ack(ack), .evt_count(evt_count),
        .half_seen(half_seen), .irq(irq), .ovf(ovf), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic [7:0] th;
        logic       k, s, l;
        logic [12:0] e;
    } vec_t;
    vec_t tbl[15];

    function automatic logic [12:0] ex(input int c, input logic h, input logic i, input logic o, input logic [1:0] s);
        logic [7:0] cc;
        cc = c[7:0];
        return {cc, h, i, o, s};
    endfunction

    task automatic check(input string nm, input logic [12:0] e);
        logic [12:0] g;
        g = {evt_count, half_seen, irq, ovf, state};
        n_vec++;
        if (g !== e) begin
            n_miss++;
            $display("FAIL %s: got cnt=%0d half=%b irq=%b ovf=%b state=%b, expected cnt=%0d half=%b irq=%b ovf=%b state=%b",
                     nm, g[12:5], g[4], g[3], g[2], g[1:0], e[12:5], e[4], e[3], e[2], e[1:0]);
        end
    endtask

    task automatic step(input logic a, input logic [7:0] th, input logic k, input logic s, input logic l,
                        input bit chk, input logic [12:0] e, input string nm);
        @(negedge clk);
        arm = a; threshold = th; ack = k; rcos = s; rcol = l;
        if (chk) sb.push_back(e);
        @(posedge clk);
        #1;
        if (chk) check(nm, sb.pop_front());
    endtask

    task automatic up(input logic a, input logic [7:0] th, input logic k, input bit chk,
                      input logic [12:0] e, input string nm);
        step(a, th, k, (q == 4'd7) || (q == 4'd15), q == 4'd15, chk, e, nm);
        q = q + 4'd1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        #1;
        sb.push_back(ex(0, 0, 0, 0, 2'b00));
        check("reset", sb.pop_front());
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit last;
        tbl[0]  = '{1'b0, 8'd2, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 2'b00)};
        tbl[1]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, ex(0, 0, 0, 0, 2'b01)};
        tbl[2]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, ex(0, 1, 0, 0, 2'b01)};
        tbl[3]  = '{1'b1, 8'd2, 1'b1, 1'b0, 1'b0, ex(0, 1, 0, 0, 2'b01)};
        tbl[4]  = '{1'b1, 8'd2, 1'b0, 1'b0, 1'b1, ex(1, 0, 0, 0, 2'b01)};
        tbl[5]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, ex(1, 1, 0, 0, 2'b01)};
        tbl[6]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, ex(2, 0, 1, 0, 2'b10)};
        tbl[7]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, ex(2, 1, 1, 0, 2'b10)};
        tbl[8]  = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b1, ex(2, 0, 1, 1, 2'b10)};
        tbl[9]  = '{1'b0, 8'd2, 1'b0, 1'b0, 1'b0, ex(2, 0, 0, 1, 2'b00)};
        tbl[10] = '{1'b0, 8'd2, 1'b1, 1'b0, 1'b0, ex(2, 0, 0, 1, 2'b00)};
        tbl[11] = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, ex(0, 0, 0, 0, 2'b01)};
        tbl[12] = '{1'b1, 8'd5, 1'b0, 1'b1, 1'b1, ex(1, 0, 0, 0, 2'b01)};
        tbl[13] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b1, ex(2, 0, 0, 0, 2'b01)};
        tbl[14] = '{1'b0, 8'd1, 1'b0, 1'b1, 1'b1, ex(2, 0, 0, 0, 2'b00)};

        repeat (2) @(posedge clk);
        #1;
        sb.push_back(ex(0, 0, 0, 0, 2'b00));
        check("power_on_reset", sb.pop_front());
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 15; i++)
            step(tbl[i].a, tbl[i].th, tbl[i].k, tbl[i].s, tbl[i].l, 1'b1, tbl[i].e, $sformatf("vec%0d", i));

        do_reset();
        step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 2'b01), "arm");
        q = 4'd0;
        for (int c = 0; c < 48; c++) begin
            int w;
            w = c / 16 + 1;
            up(1'b1, 8'd3, 1'b0, (q == 4'd7) || (q == 4'd15),
               (q == 4'd7) ? ex(w - 1, 1, 0, 0, 2'b01) : ((w == 3) ? ex(3, 0, 1, 0, 2'b10) : ex(w, 0, 0, 0, 2'b01)),
               (q == 4'd7) ? "half_run" : "wrap_run");
        end
        for (int c = 0; c < 32; c++) begin
            int w;
            w = c / 16 + 4;
            up(1'b1, 8'd3, 1'b0, (q == 4'd7) || (q == 4'd15),
               (q == 4'd7) ? ex(3, 1, 1, (w == 4) ? 1'b0 : 1'b1, 2'b10) : ex(3, 0, 1, 1, 2'b10),
               (q == 4'd7) ? "half_flag" : "wrap_flag_ovf");
        end
        for (int c = 0; c < 15; c++)
            up(1'b1, 8'd3, 1'b0, q == 4'd14, ex(3, 1, 1, 1, 2'b10), "flag_prewrap");
        up(1'b1, 8'd1, 1'b1, 1'b1, ex(1, 0, 1, 1, 2'b10), "ack_wrap_th1");
        up(1'b1, 8'd1, 1'b1, 1'b1, ex(0, 0, 0, 1, 2'b01), "ack_to_run");

        for (int w = 1; w <= 20; w++) begin
            for (int c = 0; c < 16; c++) begin
                last = (q == 4'd15);
                up(1'b1, 8'd0, 1'b0, last, ex(w, 0, 0, 1, 2'b01), "wrap_thr0");
                if (last) break;
            end
        end
        for (int c = 0; c < 15; c++)
            up(1'b1, 8'd0, 1'b0, 1'b0, ex(0, 0, 0, 0, 2'b00), "");
        up(1'b0, 8'd0, 1'b0, 1'b1, ex(20, 1, 0, 1, 2'b00), "disarm_wrap");

        step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 2'b01), "rearm");
        step(1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, ex(1, 0, 1, 0, 2'b10), "fire_th1");
        step(1'b1, 8'd1, 1'b0, 1'b1, 1'b1, 1'b1, ex(1, 0, 1, 1, 2'b10), "ovf_th1");
        step(1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 1'b1, ex(1, 1, 1, 1, 2'b10), "half_pre_clr");
        @(negedge clk);
        rcos = 1'b0; rcol = 1'b0;
        #2 clr = 1'b1;
        #1;
        sb.push_back(ex(0, 0, 0, 0, 2'b00));
        check("clr_async", sb.pop_front());
        @(posedge clk);
        #1;
        sb.push_back(ex(0, 0, 0, 0, 2'b00));
        check("clr_held", sb.pop_front());
        @(negedge clk);
        clr = 1'b0;
        step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, ex(0, 0, 0, 0, 2'b01), "run_after_clr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
